or4_resp_checker: RTL and testbench

//  Synthesizable response checker for a 4-input OR gate under test. Receives the

---
 rtl/or4_chk_pkg.sv | 23 ++
 rtl/or4_settle_det.sv | 46 ++++
 rtl/or4_resp_checker.sv | 132 +++++++++++++
 tb/tb_or4_resp_checker.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/or4_chk_pkg.sv
// Shared definitions for the 4-input OR response checker.
//   VEC_W      : width of the stimulus vector {d,c,b,a}
//   CNT_W      : width of the check / mismatch counters
//   state_t    : checker FSM states
//   or4_expect : reference function of the gate under test
package or4_chk_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic logic or4_expect(input logic [VEC_W-1:0] v);
    return |v;
  endfunction

endpackage

// File: rtl/or4_settle_det.sv
// Stimulus settle detector: latches the applied vector and counts how many
// consecutive cycles it has stayed unchanged.
//   clk, rstn : clock, asynchronous active-low reset
//   vec       : live stimulus vector {d,c,b,a}
//   load      : unconditionally latch vec and clear the stable counter
//   count_en  : settling in progress; relatch on change, else count
//   vec_q     : latched vector
//   changed   : live vector differs from the latched one
//   stable    : vector unchanged and counter at SETTLE_CYCLES-1
module or4_settle_det
  import or4_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [VEC_W-1:0] vec,
  input  logic             load,
  input  logic             count_en,
  output logic [VEC_W-1:0] vec_q,
  output logic             changed,
  output logic             stable
);

  // Counter only ever needs to reach SETTLE_CYCLES-1.
  localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

  logic [SC_W-1:0] cnt;

  assign changed = (vec != vec_q);
  assign stable  = !changed && (cnt == SC_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vec_q <= '0;
      cnt   <= '0;
    end else if (load || (count_en && changed)) begin
      vec_q <= vec;
      cnt   <= '0;
    end else if (count_en && (cnt != SC_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/or4_resp_checker.sv
// Response checker for a 4-input OR gate. Waits for the stimulus to settle,
// samples the gate output once per distinct applied vector, and accumulates
// check/mismatch counts, first-failure capture and input-code coverage.
//   clk, rstn      : clock, asynchronous active-low reset
//   start          : one-cycle pulse, clears results and (re)starts a run
//   a, b, c, d     : stimulus bits applied to the gate
//   s              : gate output
//   busy / done    : run in progress / run finished (held until start)
//   pass           : no mismatches, valid with done
//   chk_cnt        : vectors checked this run
//   err_cnt        : mismatches this run, saturating
//   first_err_vec  : {s,d,c,b,a} of first mismatch
//   first_err_vld  : a mismatch has been recorded
//   cov_mask       : bit k set once code k={d,c,b,a} has been checked
module or4_resp_checker
  import or4_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_VECTORS   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  input  logic                  s,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      chk_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [VEC_W:0]        first_err_vec,
  output logic                  first_err_vld,
  output logic [2**VEC_W-1:0]   cov_mask
);

  localparam logic [CNT_W-1:0] LAST_CHK = CNT_W'(NUM_VECTORS - 1);

  state_t           state;
  logic [VEC_W-1:0] vec_in;
  logic [VEC_W-1:0] vec_q;
  logic             changed;
  logic             stable;
  logic             load;
  logic             count_en;
  logic             mismatch;

  assign vec_in   = {d, c, b, a};
  assign mismatch = (s != or4_expect(vec_q));

  // The detector is steered by the current state: start always relatches,
  // HOLD relatches on the first change after a check.
  always_comb begin
    load     = start;
    count_en = 1'b0;
    case (state)
      ST_SETTLE: count_en = 1'b1;
      ST_HOLD:   load     = start | changed;
      default:   ;
    endcase
  end

  or4_settle_det #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk      (clk),
    .rstn     (rstn),
    .vec      (vec_in),
    .load     (load),
    .count_en (count_en),
    .vec_q    (vec_q),
    .changed  (changed),
    .stable   (stable)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      chk_cnt       <= '0;
      err_cnt       <= '0;
      first_err_vec <= '0;
      first_err_vld <= 1'b0;
      cov_mask      <= '0;
    end else if (start) begin
      state         <= ST_SETTLE;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      chk_cnt       <= '0;
      err_cnt       <= '0;
      first_err_vec <= '0;
      first_err_vld <= 1'b0;
      cov_mask      <= '0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (stable) state <= ST_CHECK;
        end
        ST_CHECK: begin
          chk_cnt         <= chk_cnt + 1'b1;
          cov_mask[vec_q] <= 1'b1;
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!first_err_vld) begin
              first_err_vec <= {s, vec_q};
              first_err_vld <= 1'b1;
            end
          end
          if (chk_cnt == LAST_CHK) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Include this cycle's result since err_cnt is not yet updated.
            pass  <= (err_cnt == '0) && !mismatch;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (changed) state <= ST_SETTLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_or4_resp_checker.sv
// Directed self-checking bench for or4_resp_checker (SETTLE_CYCLES=2,
// NUM_VECTORS=16). Inputs change 1 time unit after a rising edge; outputs
// are sampled at the same point, well clear of the next edge.
module tb_or4_resp_checker;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  code = 4'd0;
  logic        s;
  logic        bad_en = 1'b0;
  logic [3:0]  bad_code = 4'd0;

  logic        busy, done, pass, first_err_vld;
  logic [7:0]  chk_cnt, err_cnt;
  logic [4:0]  first_err_vec;
  logic [15:0] cov_mask;

  int unsigned total = 0;
  int unsigned bad = 0;

  // Gate under test: a correct OR unless a faulty code is selected.
  assign s = (bad_en && (code == bad_code)) ? 1'b0 : |code;

  always #5 clk = ~clk;

  or4_resp_checker #(
    .SETTLE_CYCLES(2),
    .NUM_VECTORS  (16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .a             (code[0]),
    .b             (code[1]),
    .c             (code[2]),
    .d             (code[3]),
    .s             (s),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .chk_cnt       (chk_cnt),
    .err_cnt       (err_cnt),
    .first_err_vec (first_err_vec),
    .first_err_vld (first_err_vld),
    .cov_mask      (cov_mask)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start pulse together with the first code; returns 1 unit after the edge.
  task automatic pulse_start(input logic [3:0] c0);
    code  = c0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic hold_code(input logic [3:0] c, input int unsigned n);
    code = c;
    tick(n);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_pass"}, 32'(pass), 32'd0);
    check_val({tag, "_chk"},  32'(chk_cnt), 32'd0);
    check_val({tag, "_err"},  32'(err_cnt), 32'd0);
    check_val({tag, "_fvec"}, 32'(first_err_vec), 32'd0);
    check_val({tag, "_fvld"}, 32'(first_err_vld), 32'd0);
    check_val({tag, "_cov"},  32'(cov_mask), 32'd0);
  endtask

  initial begin
    // Reset state
    tick(3);
    check_all_zero("rst");
    rstn = 1'b1;
    tick(2);
    check_all_zero("idle");

    // 1: full sweep, correct gate
    pulse_start(4'd0);
    check_val("t1_busy", 32'(busy), 32'd1);
    tick(3);
    check_val("t1_first_chk", 32'(chk_cnt), 32'd1);
    for (int i = 1; i < 16; i++) hold_code(4'(i), 4);
    check_val("t1_done", 32'(done), 32'd1);
    check_val("t1_busy_lo", 32'(busy), 32'd0);
    check_val("t1_pass", 32'(pass), 32'd1);
    check_val("t1_chk", 32'(chk_cnt), 32'd16);
    check_val("t1_err", 32'(err_cnt), 32'd0);
    check_val("t1_fvld", 32'(first_err_vld), 32'd0);
    check_val("t1_cov", 32'(cov_mask), 32'hFFFF);
    tick(5);
    check_val("t1_done_held", 32'(done), 32'd1);

    // 2: faulty output on code 0101
    bad_en   = 1'b1;
    bad_code = 4'b0101;
    pulse_start(4'd0);
    check_val("t2_done_clr", 32'(done), 32'd0);
    check_val("t2_chk_clr", 32'(chk_cnt), 32'd0);
    tick(3);
    for (int i = 1; i < 16; i++) hold_code(4'(i), 4);
    check_val("t2_done", 32'(done), 32'd1);
    check_val("t2_err", 32'(err_cnt), 32'd1);
    check_val("t2_fvec", 32'(first_err_vec), 32'b0_0101);
    check_val("t2_fvld", 32'(first_err_vld), 32'd1);
    check_val("t2_pass", 32'(pass), 32'd0);
    check_val("t2_chk", 32'(chk_cnt), 32'd16);
    bad_en = 1'b0;

    // 3: toggling faster than settle time, then a held code
    pulse_start(4'd1);
    for (int i = 0; i < 8; i++) hold_code((i % 2 == 0) ? 4'd2 : 4'd3, 1);
    check_val("t3_no_chk", 32'(chk_cnt), 32'd0);
    hold_code(4'd6, 3);
    check_val("t3_not_yet", 32'(chk_cnt), 32'd0);
    tick(1);
    check_val("t3_chk", 32'(chk_cnt), 32'd1);
    check_val("t3_cov", 32'(cov_mask), 32'h0040);

    // 4: restart while busy, hold one code for 20 cycles
    pulse_start(4'd3);
    check_val("t4_restart_chk", 32'(chk_cnt), 32'd0);
    check_val("t4_restart_cov", 32'(cov_mask), 32'd0);
    tick(19);
    check_val("t4_chk", 32'(chk_cnt), 32'd1);
    check_val("t4_cov", 32'(cov_mask), 32'h0008);
    check_val("t4_busy", 32'(busy), 32'd1);

    // 5: reset mid-run after 7 checks
    pulse_start(4'd0);
    tick(3);
    for (int i = 1; i < 7; i++) hold_code(4'(i), 4);
    check_val("t5_chk7", 32'(chk_cnt), 32'd7);
    rstn = 1'b0;
    #1;
    check_all_zero("t5_rst");
    #1;
    rstn = 1'b1;
    tick(2);
    pulse_start(4'd0);
    tick(3);
    check_val("t5_rerun_chk", 32'(chk_cnt), 32'd1);
    check_val("t5_rerun_cov", 32'(cov_mask), 32'h0001);

    // 6: start pulse after 9 checks
    for (int i = 1; i < 9; i++) hold_code(4'(i), 4);
    check_val("t6_chk9", 32'(chk_cnt), 32'd9);
    pulse_start(4'd9);
    check_val("t6_chk_clr", 32'(chk_cnt), 32'd0);
    check_val("t6_cov_clr", 32'(cov_mask), 32'd0);
    check_val("t6_busy", 32'(busy), 32'd1);
    tick(3);
    check_val("t6_chk1", 32'(chk_cnt), 32'd1);
    check_val("t6_cov1", 32'(cov_mask), 32'h0200);
    for (int i = 10; i < 16; i++) hold_code(4'(i), 4);
    for (int i = 0; i < 9; i++) hold_code(4'(i), 4);
    check_val("t6_done", 32'(done), 32'd1);
    check_val("t6_pass", 32'(pass), 32'd1);
    check_val("t6_cov", 32'(cov_mask), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
